snn_network_sequencer: RTL

SNN_NETWORK_SEQUENCER -- requirements
Module: snn_network_sequencer

---
 rtl/snn_network_sequencer_if.sv | 28 ++
 rtl/snn_network_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/snn_network_sequencer_if.sv
// Handshake/bus bundle between the SNN sequencer (master) and the core controller,
// spike memory and neuron array (slave).
interface snn_network_sequencer_if #(
  parameter int NUM_INPUTS = 4,
  parameter int SIM_TIME   = 16
);
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int TW = (SIM_TIME > 1) ? $clog2(SIM_TIME) : 1;

  logic          network_en;
  logic          neuron_ack;
  logic          spike_rd_en;
  logic [AW-1:0] spike_addr;
  logic          neuron_update;
  logic [TW-1:0] timestep;
  logic          sim_time_done;
  logic          network_done;

  modport master (
    input  network_en, neuron_ack,
    output spike_rd_en, spike_addr, neuron_update, timestep, sim_time_done, network_done
  );

  modport slave (
    output network_en, neuron_ack,
    input  spike_rd_en, spike_addr, neuron_update, timestep, sim_time_done, network_done
  );
endinterface

// File: rtl/snn_network_sequencer.sv
// Timestep sequencer for a spiking network: fetch NUM_INPUTS spikes, request a neuron
// update, repeat for SIM_TIME steps. Define SNN_SEQ_PAUSE_EN to pause (not abort) on network_en=0.
module snn_network_sequencer #(
  parameter int NUM_INPUTS = 4,
  parameter int SIM_TIME   = 16
) (
  input logic                    clk,
  input logic                    rst,
  snn_network_sequencer_if.master bus
);
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int TW = (SIM_TIME > 1) ? $clog2(SIM_TIME) : 1;
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_INPUTS - 1);
  localparam logic [TW-1:0] TS_LAST  = TW'(SIM_TIME - 1);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_ts, w_ts_nxt;
  logic          r_paused, w_paused_nxt;
  logic          w_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_ts     <= '0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_ts     <= w_ts_nxt;
      r_paused <= w_paused_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_ts_nxt     = r_ts;
    w_paused_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        w_ts_nxt  = '0;
        if (bus.network_en) w_state_nxt = FETCH;
      end
      FETCH, UPDATE: begin
        if (!bus.network_en) begin
`ifdef SNN_SEQ_PAUSE_EN
          w_paused_nxt = 1'b1;
`else
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_ts_nxt    = '0;
`endif
        end else if (r_paused) begin
          // First enabled cycle after a pause only re-exposes the strobe; no progress yet.
          w_paused_nxt = 1'b0;
        end else if (r_state == FETCH) begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = UPDATE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (bus.neuron_ack) begin
          if (r_ts == TS_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_ts_nxt    = r_ts + 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_ts_nxt    = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_ts_nxt    = '0;
      end
    endcase
  end

  assign w_run = (r_state == FETCH) || (r_state == UPDATE);

  assign bus.spike_rd_en   = (r_state == FETCH) && !r_paused;
  assign bus.spike_addr    = r_idx;
  assign bus.neuron_update = (r_state == UPDATE) && !r_paused;
  assign bus.timestep      = r_ts;
  assign bus.sim_time_done = w_run && (r_ts == TS_LAST);
  assign bus.network_done  = (r_state == DONE);
endmodule
